lifting_mac: RTL and testbench
==============================

// Module: lifting_mac
// PURPOSE
//   Lifting-step multiply-accumulate unit for the 1-D recursive 9/7 DWT datapath.
//   Computes d = in3 + cons*(in0 + in1): one predict/update step on two neighbours
//   plus the opposite-phase sample.
//   Four instances are chained in the transform, using the alpha/beta/gamma/delta constants.
//   Fully pipelined, one sample per clock, no backpressure.
// PARAMETERS
//   SIZE   32  data width of in0/in1/in3/d and cons (two's complement, signed)
//   FRAC   0   fractional bits of cons (Q(SIZE-FRAC).FRAC); 0 = integer constant
//   SAT    1   1 = saturate d to signed SIZE range; 0 = wrap (keep low SIZE bits)
// PORTS
//   clk        in   1     clock, all state on rising edge
//   resetn     in   1     synchronous, active-low reset
//   in_valid   in   1     in0/in1/in3/cons valid this cycle
//   in0        in   SIZE  left neighbour sample (signed)
//   in1        in   SIZE  right neighbour sample (signed)
//   in3        in   SIZE  sample being updated (signed)
//   cons       in   SIZE  lifting coefficient (signed, FRAC fractional bits)
//   d          out  SIZE  lifting result (signed)
//   out_valid  out  1     d valid this cycle
// BEHAVIOUR
//   - Reset is sampled on the clk edge. While resetn=0: d=0, out_valid=0, all pipeline regs=0.
//   - Stage 1 (edge k): sum = in0+in1 sign-extended to SIZE+1 bits, no overflow.
//     Also registers in3, cons, and v1 = in_valid.
//   - Stage 2 (edge k+1):
//       prod = sum*cons, full 2*SIZE+1 bits, signed.
//       scaled = prod >>> FRAC, arithmetic shift (truncate toward -inf).
//       acc = scaled + sign-extended in3.
//       d <= SAT ? clamp(acc, -2^(SIZE-1), 2^(SIZE-1)-1) : acc[SIZE-1:0].
//       out_valid <= v1.
//   - Latency: inputs sampled at edge k appear on d/out_valid after edge k+1 (2 cycles).
//   - Throughput 1/cycle; back-to-back in_valid gives back-to-back out_valid.
//   - in_valid=0: pipeline still advances. d updates from whatever data is present;
//     out_valid is low. Consumers must ignore d when out_valid=0.
//   - Saturation endpoints: acc exactly at max/min passes unchanged.
//     One beyond either limit clamps to that limit.
//   - Reset mid-stream: in-flight samples are dropped.
//     First out_valid comes 2 cycles after the first in_valid following reset release.
//   - cons=0: d = in3. in0=-in1: d = in3 regardless of cons.
//   - No combinational path from any input to d or out_valid.
// TESTING
//   1 Integer: cons=2, in0=1, in1=2, in3=5, in_valid=1 -> two edges later d=11, out_valid=1.
//   2 Signed: cons=3, in0=-3, in1=-1, in3=10 -> d=-2.
//     Also cons=-4, in0=5, in1=0, in3=0 -> d=-20.
//   3 Pipeline: stream cases 1,2 on consecutive cycles, then in_valid=0.
//     -> d=11 then -2 on consecutive cycles; out_valid 1,1,0.
//   4 Saturation SAT=1: cons=2, in0=in1=32'h7FFFFFFF, in3=0 -> d=32'h7FFFFFFF.
//     cons=2, in0=in1=32'h80000000 -> d=32'h80000000.
//     With SAT=0 the same first case gives d=32'hFFFFFFFC.
//   5 Fixed point FRAC=8: cons=32'h180 (1.5), in0=4, in1=4, in3=1 -> d=13.
//     cons=32'h080 (0.5), in0=-1, in1=0, in3=0 -> d=-1 (floor).
//   6 Reset: drive valid stream, assert resetn=0 for 1 cycle mid-stream.
//     -> d=0, out_valid=0 next cycle; no stale sample emerges after release.

Source files
------------

// File: rtl/lifting_mac.sv
// Lifting-step MAC for the 9/7 DWT: d = in3 + cons*(in0+in1), optional saturation.
// Two-cycle latency, one sample per clock, no backpressure.
module lifting_mac #(
  parameter int SIZE = 32,
  parameter int FRAC = 0,
  parameter int SAT  = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic signed [SIZE-1:0] in0,
  input  logic signed [SIZE-1:0] in1,
  input  logic signed [SIZE-1:0] in3,
  input  logic signed [SIZE-1:0] cons,
  output logic signed [SIZE-1:0] d,
  output logic                   out_valid
);

  localparam int PW = 2*SIZE + 1;
  localparam int AW = PW + 1;

  logic signed [SIZE:0]   sum_q;
  logic signed [SIZE-1:0] in3_q;
  logic signed [SIZE-1:0] cons_q;
  logic                   v1_q;

  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   scaled;
  logic signed [AW-1:0]   acc;
  logic                   fits;
  logic        [SIZE-1:0] sat_val;
  logic        [SIZE-1:0] d_next;

  // Stage 1: one extra bit on the neighbour sum so it can never overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sum_q  <= '0;
      in3_q  <= '0;
      cons_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      sum_q  <= $signed({in0[SIZE-1], in0}) + $signed({in1[SIZE-1], in1});
      in3_q  <= in3;
      cons_q <= cons;
      v1_q   <= in_valid;
    end
  end

  // Stage 2 datapath: full-width product, floor scaling, then clamp or wrap.
  always_comb begin
    prod    = PW'(sum_q) * PW'(cons_q);
    scaled  = prod >>> FRAC;
    acc     = AW'(scaled) + AW'(in3_q);
    fits    = (acc[AW-1:SIZE-1] == {(AW-SIZE+1){acc[AW-1]}});
    sat_val = acc[AW-1] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    d_next  = acc[SIZE-1:0];
    if (SAT != 0 && !fits) begin
      d_next = sat_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      d         <= '0;
      out_valid <= 1'b0;
    end else begin
      d         <= d_next;
      out_valid <= v1_q;
    end
  end

endmodule

// File: tb/tb_lifting_mac.sv
// Bench for lifting_mac: three configurations (sat, wrap, Q.8) driven in parallel,
// checked every cycle against an arithmetic reference plus hand-computed literals.
module tb_lifting_mac;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic signed [31:0] in0 = '0, in1 = '0, in3 = '0, cons = '0;
  logic signed [31:0] d_o [3];
  logic               ov_o [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lifting_mac #(.SIZE(32), .FRAC(0), .SAT(1)) u_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in0(in0), .in1(in1),
    .in3(in3), .cons(cons), .d(d_o[0]), .out_valid(ov_o[0]));
  lifting_mac #(.SIZE(32), .FRAC(0), .SAT(0)) u_wrap (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in0(in0), .in1(in1),
    .in3(in3), .cons(cons), .d(d_o[1]), .out_valid(ov_o[1]));
  lifting_mac #(.SIZE(32), .FRAC(8), .SAT(1)) u_frac (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in0(in0), .in1(in1),
    .in3(in3), .cons(cons), .d(d_o[2]), .out_valid(ov_o[2]));

  // Directed vectors: in0, in1, in3, cons and hand-computed d for (sat, wrap, Q.8).
  localparam int NV = 13;
  logic [31:0] v_in0 [NV] = '{32'd1, -32'sd3, 32'd5, 32'h7FFFFFFF, 32'h80000000, 32'd4, -32'sd1,
                              32'h7FFFFFFE, 32'h7FFFFFFF, 32'h80000001, 32'h80000000, 32'd1000, 32'd5};
  logic [31:0] v_in1 [NV] = '{32'd2, -32'sd1, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'd4, 32'd0,
                              32'd0, 32'd0, 32'd0, 32'd0, -32'sd1000, 32'd6};
  logic [31:0] v_in3 [NV] = '{32'd5, 32'd10, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0,
                              32'd1, 32'd1, -32'sd1, -32'sd1, 32'd77, -32'sd9};
  logic [31:0] v_con [NV] = '{32'd2, 32'd3, -32'sd4, 32'd2, 32'd2, 32'h180, 32'h080,
                              32'd1, 32'd1, 32'd1, 32'd1, 32'd12345, 32'd0};
  logic [31:0] v_e0 [NV] = '{32'd11, -32'sd2, -32'sd20, 32'h7FFFFFFF, 32'h80000000, 32'd3073, -32'sd128,
                             32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'd77, -32'sd9};
  logic [31:0] v_e1 [NV] = '{32'd11, -32'sd2, -32'sd20, 32'hFFFFFFFC, 32'h00000000, 32'd3073, -32'sd128,
                             32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'd77, -32'sd9};
  logic [31:0] v_e2 [NV] = '{32'd5, 32'd9, -32'sd1, 32'h01FFFFFF, 32'hFE000000, 32'd13, -32'sd1,
                             32'h00800000, 32'h00800000, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'd77, -32'sd9};

  // Reference: exact integer result, floor division by 2^frac, then clamp or wrap.
  function automatic logic [31:0] ref_d(input logic signed [31:0] a, input logic signed [31:0] b,
                                        input logic signed [31:0] c, input logic signed [31:0] k,
                                        input int frac, input bit sat);
    logic signed [127:0] p, q, div, r;
    p   = (128'(a) + 128'(b)) * 128'(k);
    div = 128'sd1 <<< frac;
    q   = p / div;
    if (p < 0 && q * div != p) q = q - 1;
    r   = q + 128'(c);
    if (sat && r > 128'sd2147483647) return 32'h7FFFFFFF;
    if (sat && r < -128'sd2147483648) return 32'h80000000;
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-edge history of what the DUT sampled, with reference results per configuration.
  bit          rst_h [512];
  bit          v_h   [512];
  int          idx_h [512];
  logic [31:0] m_h   [512][3];
  int          ec = 0;
  int          cur_idx = -1;

  always @(posedge clk) begin
    rst_h[ec] = !resetn;
    v_h[ec]   = in_valid;
    idx_h[ec] = cur_idx;
    m_h[ec][0] = ref_d(in0, in1, in3, cons, 0, 1'b1);
    m_h[ec][1] = ref_d(in0, in1, in3, cons, 0, 1'b0);
    m_h[ec][2] = ref_d(in0, in1, in3, cons, 8, 1'b1);
    ec++;
  end

  // Output after edge n reflects the sample from edge n-1 unless either edge was in reset.
  always @(negedge clk) begin
    if (ec > 0) begin
      int n;
      bit live, ev;
      logic [31:0] ed, lit;
      n    = ec - 1;
      live = !rst_h[n] && n > 0 && !rst_h[n-1];
      ev   = live ? v_h[n-1] : 1'b0;
      for (int i = 0; i < 3; i++) begin
        ed = live ? m_h[n-1][i] : 32'd0;
        chk($sformatf("out_valid[%0d]", i), {31'd0, ov_o[i]}, {31'd0, ev});
        chk($sformatf("d[%0d]", i), d_o[i], ed);
        if (ev && idx_h[n-1] >= 0) begin
          lit = (i == 0) ? v_e0[idx_h[n-1]] : (i == 1) ? v_e1[idx_h[n-1]] : v_e2[idx_h[n-1]];
          chk($sformatf("lit_d[%0d] vec%0d", i, idx_h[n-1]), d_o[i], lit);
          chk($sformatf("ref_vs_lit[%0d] vec%0d", i, idx_h[n-1]), m_h[n-1][i], lit);
        end
      end
    end
  end

  task automatic drive(input int idx, input bit v, input bit rn);
    @(negedge clk);
    resetn   = rn;
    in_valid = v;
    cur_idx  = v ? idx : -1;
    if (idx >= 0) begin
      in0 = v_in0[idx]; in1 = v_in1[idx]; in3 = v_in3[idx]; cons = v_con[idx];
    end else begin
      in0 = $urandom; in1 = $urandom; in3 = $urandom; cons = $urandom_range(0, 255);
    end
  endtask

  initial begin
    repeat (3) drive(-1, 1'b1, 1'b0);
    drive(-1, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b1);
    repeat (3) drive(-1, 1'b0, 1'b1);
    for (int i = 2; i < NV; i++) drive(i, 1'b1, 1'b1);
    repeat (3) drive(-1, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b1);
    drive(2, 1'b1, 1'b0);
    drive(3, 1'b1, 1'b1);
    drive(4, 1'b1, 1'b1);
    repeat (4) drive(-1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
